// File: rtl/cpu_seq_pkg.sv
// cpu_seq_pkg
// Shared types and constants for the 16-bit CPU fetch/decode/execute sequencer:
// state encodings (also visible on state_o), opcode values, opcode classes and
// instruction field positions.
package cpu_seq_pkg;

   typedef enum logic [2:0] {
      ST_FETCH     = 3'd0,
      ST_DECODE    = 3'd1,
      ST_EXECUTE   = 3'd2,
      ST_MEM       = 3'd3,
      ST_WRITEBACK = 3'd4,
      ST_HALT      = 3'd5,
      ST_FAULT     = 3'd6
   } state_e;

   typedef enum logic [2:0] {
      CLS_NOP    = 3'd0,
      CLS_ALU    = 3'd1,
      CLS_LOAD   = 3'd2,
      CLS_STORE  = 3'd3,
      CLS_JUMP   = 3'd4,
      CLS_BRANCH = 3'd5,
      CLS_HALT   = 3'd6
   } op_class_e;

   localparam logic [3:0] OP_NOP    = 4'h0;
   localparam logic [3:0] OP_ALU_LO = 4'h1;
   localparam logic [3:0] OP_ALU_HI = 4'h7;
   localparam logic [3:0] OP_LOAD   = 4'h8;
   localparam logic [3:0] OP_STORE  = 4'h9;
   localparam logic [3:0] OP_JUMP   = 4'hA;
   localparam logic [3:0] OP_BRANCH = 4'hB;
   localparam logic [3:0] OP_HALT   = 4'hF;

   localparam int OPC_MSB  = 15;
   localparam int OPC_LSB  = 12;
   localparam int REG1_MSB = 11;
   localparam int REG1_LSB = 10;
   localparam int REG2_MSB = 9;
   localparam int REG2_LSB = 8;
   localparam int ADDR_MSB = 7;
   localparam int ADDR_LSB = 0;

   function automatic logic is_alu_op(input logic [3:0] opc);
      return (opc >= OP_ALU_LO) && (opc <= OP_ALU_HI);
   endfunction

endpackage

// File: rtl/cpu_seq_opdecode.sv
// cpu_seq_opdecode
// Purely combinational opcode classifier, shared with the control unit bench.
// Ports:
//   opcode_i   [3:0]  instruction opcode field
//   op_class_o        opcode class (1100-1110 fold into NOP)
module cpu_seq_opdecode
   import cpu_seq_pkg::*;
(
   input  logic [3:0] opcode_i,
   output op_class_e  op_class_o
);

   always_comb begin
      op_class_o = CLS_NOP;
      if (is_alu_op(opcode_i)) begin
         op_class_o = CLS_ALU;
      end else begin
         case (opcode_i)
            OP_LOAD:   op_class_o = CLS_LOAD;
            OP_STORE:  op_class_o = CLS_STORE;
            OP_JUMP:   op_class_o = CLS_JUMP;
            OP_BRANCH: op_class_o = CLS_BRANCH;
            OP_HALT:   op_class_o = CLS_HALT;
            default:   op_class_o = CLS_NOP;
         endcase
      end
   end

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer
// Multi-cycle fetch/decode/execute sequencer. Owns PC and IR, arbitrates the
// single RAM port between instruction fetch and LOAD/STORE, and issues
// one-cycle ALU-enable and register-write strobes. All outputs are Moore
// functions of the registered state.
//
// Optional build macro: CPU_SEQ_MEM_TIMEOUT_EN adds a RAM wait watchdog that
// moves to FAULT after MEM_TIMEOUT consecutive wait cycles. Without it, fault
// is tied 0 and FAULT is unreachable.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   run                 allow a new fetch to start
//   mem_rdata/ready     RAM read data and completion
//   branch_check        branch condition from control unit
//   mem_req/we/addr     RAM request
//   pc, ir              program counter, instruction register
//   alu_en, reg_write   one-cycle strobes
//   halted, fault       sticky status
//   state_o             current state encoding
//
// State table:
//   state     | meaning
//   FETCH     | idle or reading instruction at pc
//   DECODE    | one settle cycle after IR load
//   EXECUTE   | act on opcode class, ALU strobe
//   MEM       | LOAD/STORE data access at ir[7:0]
//   WRITEBACK | register-file write strobe, pc+1
//   HALT      | stopped until reset
//   FAULT     | RAM timeout, stopped until reset
module cpu_sequencer
   import cpu_seq_pkg::*;
#(
   parameter int unsigned        PC_W        = 8,
   parameter int unsigned        INSTR_W     = 16,
   parameter logic [PC_W-1:0]    RESET_PC    = '0,
   parameter int unsigned        MEM_TIMEOUT = 15
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               run,
   input  logic [INSTR_W-1:0] mem_rdata,
   input  logic               mem_ready,
   input  logic               branch_check,
   output logic               mem_req,
   output logic               mem_we,
   output logic [PC_W-1:0]    mem_addr,
   output logic [PC_W-1:0]    pc,
   output logic [INSTR_W-1:0] ir,
   output logic               alu_en,
   output logic               reg_write,
   output logic               halted,
   output logic               fault,
   output logic [2:0]         state_o
);

   state_e             state_q, state_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic [INSTR_W-1:0] ir_q, ir_d;
   // Fetch request latch: run is registered so mem_req has no path from run.
   // It is loaded with run on every entry to FETCH so a running program
   // requests in the first FETCH cycle.
   logic               freq_q, freq_d;
   op_class_e          op_class;
   logic [PC_W-1:0]    target;
   logic [PC_W-1:0]    pc_inc;
   logic               req_int;
   logic               mem_timeout;

   cpu_seq_opdecode u_opdecode (
      .opcode_i   (ir_q[OPC_MSB:OPC_LSB]),
      .op_class_o (op_class)
   );

   assign target = PC_W'(ir_q[ADDR_MSB:ADDR_LSB]);
   assign pc_inc = pc_q + PC_W'(1);
   assign req_int = ((state_q == ST_FETCH) && freq_q) || (state_q == ST_MEM);

`ifdef CPU_SEQ_MEM_TIMEOUT_EN
   localparam int unsigned TMO_W = $clog2(MEM_TIMEOUT + 1);

   // Down-counter reloaded whenever the RAM is not stalling us; terminal
   // count on the MEM_TIMEOUT-th consecutive wait cycle.
   logic [TMO_W-1:0] tmo_q, tmo_d;

   always_comb begin
      tmo_d = tmo_q;
      if (!req_int || mem_ready) begin
         tmo_d = TMO_W'(MEM_TIMEOUT);
      end else begin
         tmo_d = tmo_q - TMO_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_q <= TMO_W'(MEM_TIMEOUT);
      end else begin
         tmo_q <= tmo_d;
      end
   end

   assign mem_timeout = req_int && !mem_ready && (tmo_q == TMO_W'(1));
`else
   assign mem_timeout = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      freq_d  = freq_q;
      unique case (state_q)
         ST_FETCH: begin
            if (freq_q) begin
               if (mem_ready) begin
                  ir_d    = mem_rdata;
                  freq_d  = 1'b0;
                  state_d = ST_DECODE;
               end
            end else begin
               freq_d = run;
            end
         end
         ST_DECODE: begin
            state_d = ST_EXECUTE;
         end
         ST_EXECUTE: begin
            unique case (op_class)
               CLS_ALU: begin
                  state_d = ST_WRITEBACK;
               end
               CLS_LOAD, CLS_STORE: begin
                  state_d = ST_MEM;
               end
               CLS_JUMP: begin
                  pc_d    = target;
                  freq_d  = run;
                  state_d = ST_FETCH;
               end
               CLS_BRANCH: begin
                  pc_d    = branch_check ? target : pc_inc;
                  freq_d  = run;
                  state_d = ST_FETCH;
               end
               CLS_HALT: begin
                  state_d = ST_HALT;
               end
               default: begin
                  pc_d    = pc_inc;
                  freq_d  = run;
                  state_d = ST_FETCH;
               end
            endcase
         end
         ST_MEM: begin
            if (mem_ready) begin
               if (op_class == CLS_STORE) begin
                  pc_d    = pc_inc;
                  freq_d  = run;
                  state_d = ST_FETCH;
               end else begin
                  state_d = ST_WRITEBACK;
               end
            end
         end
         ST_WRITEBACK: begin
            pc_d    = pc_inc;
            freq_d  = run;
            state_d = ST_FETCH;
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
         ST_FAULT: begin
            state_d = ST_FAULT;
         end
         default: begin
            state_d = ST_FETCH;
            freq_d  = 1'b0;
         end
      endcase

      if (mem_timeout) begin
         state_d = ST_FAULT;
         freq_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_FETCH;
         pc_q    <= RESET_PC;
         ir_q    <= '0;
         freq_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         freq_q  <= freq_d;
      end
   end

   always_comb begin
      mem_req   = req_int;
      mem_we    = (state_q == ST_MEM) && (op_class == CLS_STORE);
      mem_addr  = (state_q == ST_MEM) ? target : pc_q;
      alu_en    = (state_q == ST_EXECUTE) && (op_class == CLS_ALU);
      reg_write = (state_q == ST_WRITEBACK);
      halted    = (state_q == ST_HALT);
      fault     = (state_q == ST_FAULT);
   end

   assign pc      = pc_q;
   assign ir      = ir_q;
   assign state_o = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
module tb_cpu_sequencer;

   logic        clk;
   logic        rst_n;
   logic        run;
   logic [15:0] mem_rdata;
   logic        mem_ready;
   logic        branch_check;
   logic        mem_req;
   logic        mem_we;
   logic [7:0]  mem_addr;
   logic [7:0]  pc;
   logic [15:0] ir;
   logic        alu_en;
   logic        reg_write;
   logic        halted;
   logic        fault;
   logic [2:0]  state_o;

   cpu_sequencer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .run          (run),
      .mem_rdata    (mem_rdata),
      .mem_ready    (mem_ready),
      .branch_check (branch_check),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .pc           (pc),
      .ir           (ir),
      .alu_en       (alu_en),
      .reg_write    (reg_write),
      .halted       (halted),
      .fault        (fault),
      .state_o      (state_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [15:0] instr;
      logic        bc;
      int          fw;
      int          mw;
      logic [7:0]  pc;
      int          cyc;
      int          n_alu;
      int          n_rw;
      int          mcyc;
      logic [7:0]  addr;
      logic        we;
   } vec_t;

   typedef struct {
      bit          done;
      int          cyc;
      int          n_alu;
      int          n_rw;
      int          mcyc;
      logic [7:0]  addr;
      logic        we;
      logic [7:0]  faddr;
      int          hold_err;
      int          stray;
   } res_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ISA-level model: what one instruction does to pc, which strobes it
   // produces and how long it takes, given RAM wait counts.
   function automatic vec_t ref_step(input logic [15:0] ins, input logic bc,
                                     input logic [7:0] pc_in, input int fw, input int mw);
      vec_t e;
      logic [3:0] op;
      op = ins[15:12];
      e.instr = ins; e.bc = bc; e.fw = fw; e.mw = mw;
      e.pc = pc_in + 8'd1; e.cyc = 3 + fw; e.n_alu = 0; e.n_rw = 0;
      e.mcyc = 0; e.addr = 8'h00; e.we = 1'b0;
      if (op >= 4'd1 && op <= 4'd7) begin
         e.n_alu = 1; e.n_rw = 1; e.cyc = 4 + fw;
      end else if (op == 4'h8) begin
         e.n_rw = 1; e.mcyc = mw + 1; e.cyc = 5 + fw + mw; e.addr = ins[7:0];
      end else if (op == 4'h9) begin
         e.mcyc = mw + 1; e.cyc = 4 + fw + mw; e.addr = ins[7:0]; e.we = 1'b1;
      end else if (op == 4'hA) begin
         e.pc = ins[7:0];
      end else if (op == 4'hB) begin
         e.pc = bc ? ins[7:0] : pc_in + 8'd1;
      end else if (op == 4'hF) begin
         e.pc = pc_in;
      end
      return e;
   endfunction

   // Called at a negedge with the DUT in FETCH and requesting. Acts as the
   // RAM and observes until the DUT is back in FETCH (or HALT).
   task automatic exec(input logic [15:0] instr, input logic bc, input int fw,
                       input int mw, output res_t r);
      int  fcnt;
      int  mcnt;
      bit  left;
      r.done = 0; r.cyc = 0; r.n_alu = 0; r.n_rw = 0; r.mcyc = 0;
      r.addr = 8'h00; r.we = 1'b0; r.faddr = 8'h00; r.hold_err = 0; r.stray = 0;
      fcnt = 0; mcnt = 0; left = 0;
      for (int n = 0; n < 100; n++) begin
         if (state_o != 3'd0) left = 1;
         if (left && (state_o == 3'd0 || state_o == 3'd5)) begin
            r.done = 1;
            break;
         end
         r.cyc++;
         if (alu_en)    r.n_alu++;
         if (reg_write) r.n_rw++;
         mem_ready    = 1'b0;
         mem_rdata    = 16'($urandom);
         branch_check = (state_o == 3'd2) ? bc : ~bc;
         if (mem_req && state_o == 3'd0) begin
            if (fcnt == 0) r.faddr = mem_addr;
            mem_rdata = instr;
            mem_ready = (fcnt == fw);
            fcnt++;
         end else if (mem_req && state_o == 3'd3) begin
            if (r.mcyc == 0) begin
               r.addr = mem_addr;
               r.we   = mem_we;
            end else if (mem_addr !== r.addr || mem_we !== r.we) begin
               r.hold_err++;
            end
            r.mcyc++;
            mem_ready = (mcnt == mw);
            mcnt++;
         end else if (mem_req) begin
            r.stray++;
         end
         @(negedge clk);
      end
      mem_ready = 1'b0;
   endtask

   task automatic check_result(input string tag, input vec_t e, input logic [7:0] start_pc,
                               input res_t r);
      chk({tag, " done"},     32'(r.done), 32'd1);
      chk({tag, " pc"},       32'(pc), 32'(e.pc));
      chk({tag, " cycles"},   32'(r.cyc), 32'(e.cyc));
      chk({tag, " alu_en"},   32'(r.n_alu), 32'(e.n_alu));
      chk({tag, " reg_wr"},   32'(r.n_rw), 32'(e.n_rw));
      chk({tag, " mem_cyc"},  32'(r.mcyc), 32'(e.mcyc));
      chk({tag, " faddr"},    32'(r.faddr), 32'(start_pc));
      chk({tag, " ir"},       32'(ir), 32'(e.instr));
      chk({tag, " hold"},     32'(r.hold_err), 32'd0);
      chk({tag, " stray"},    32'(r.stray), 32'd0);
      if (e.mcyc > 0) begin
         chk({tag, " maddr"}, 32'(r.addr), 32'(e.addr));
         chk({tag, " mwe"},   32'(r.we), 32'(e.we));
      end
   endtask

   vec_t tbl[14];
   res_t r;
   vec_t e;
   logic [7:0] model_pc;
   int cnt;

   initial begin
      //               instr     bc   fw mw  pc     cyc alu rw mcyc addr  we
      tbl[0]  = '{16'h4D00, 1'b0, 0, 0, 8'h01, 4, 1, 1, 0, 8'h00, 1'b0};
      tbl[1]  = '{16'h8512, 1'b0, 0, 2, 8'h02, 7, 0, 1, 3, 8'h12, 1'b0};
      tbl[2]  = '{16'h9033, 1'b0, 0, 1, 8'h03, 5, 0, 0, 2, 8'h33, 1'b1};
      tbl[3]  = '{16'hA0FF, 1'b0, 0, 0, 8'hFF, 3, 0, 0, 0, 8'h00, 1'b0};
      tbl[4]  = '{16'h0000, 1'b0, 0, 0, 8'h00, 3, 0, 0, 0, 8'h00, 1'b0};
      tbl[5]  = '{16'hA005, 1'b0, 1, 0, 8'h05, 4, 0, 0, 0, 8'h00, 1'b0};
      tbl[6]  = '{16'hB0A0, 1'b1, 0, 0, 8'hA0, 3, 0, 0, 0, 8'h00, 1'b0};
      tbl[7]  = '{16'hA005, 1'b0, 0, 0, 8'h05, 3, 0, 0, 0, 8'h00, 1'b0};
      tbl[8]  = '{16'hB0A0, 1'b0, 0, 0, 8'h06, 3, 0, 0, 0, 8'h00, 1'b0};
      tbl[9]  = '{16'hC123, 1'b1, 2, 0, 8'h07, 5, 0, 0, 0, 8'h00, 1'b0};
      tbl[10] = '{16'h7000, 1'b0, 0, 0, 8'h08, 4, 1, 1, 0, 8'h00, 1'b0};
      tbl[11] = '{16'h1FFF, 1'b0, 3, 0, 8'h09, 7, 1, 1, 0, 8'h00, 1'b0};
      tbl[12] = '{16'h8FFE, 1'b0, 0, 0, 8'h0A, 5, 0, 1, 1, 8'hFE, 1'b0};
      tbl[13] = '{16'h9400, 1'b1, 2, 3, 8'h0B, 9, 0, 0, 4, 8'h00, 1'b1};

      rst_n = 1'b0; run = 1'b0; mem_rdata = 16'h0; mem_ready = 1'b0; branch_check = 1'b0;
      #23;
      chk("rst state", 32'(state_o), 32'd0);
      chk("rst pc", 32'(pc), 32'd0);
      chk("rst ir", 32'(ir), 32'd0);
      chk("rst outs", 32'({mem_req, mem_we, alu_en, reg_write, halted, fault}), 32'd0);

      // run=0: no request may start
      @(negedge clk); rst_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (mem_req) cnt++;
      end
      chk("run0 no req", 32'(cnt), 32'd0);
      chk("run0 state", 32'(state_o), 32'd0);
      run = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (mem_req) break;
      end
      chk("run1 req", 32'(mem_req), 32'd1);

      model_pc = 8'h00;
      for (int i = 0; i < 14; i++) begin
         exec(tbl[i].instr, tbl[i].bc, tbl[i].fw, tbl[i].mw, r);
         check_result($sformatf("vec%0d", i), tbl[i], model_pc, r);
         model_pc = tbl[i].pc;
      end

      for (int i = 0; i < 150; i++) begin
         logic [3:0]  op;
         logic [15:0] ins;
         logic        bc;
         int          fw;
         int          mw;
         op  = 4'($urandom_range(0, 14));
         ins = {op, 12'($urandom)};
         bc  = 1'($urandom);
         fw  = $urandom_range(0, 3);
         mw  = $urandom_range(0, 3);
         e = ref_step(ins, bc, model_pc, fw, mw);
         exec(ins, bc, fw, mw, r);
         check_result($sformatf("rnd%0d", i), e, model_pc, r);
         model_pc = e.pc;
      end

      // HALT: sticky, no requests
      e = ref_step(16'hF000, 1'b0, model_pc, 1, 0);
      exec(16'hF000, 1'b0, 1, 0, r);
      chk("halt cycles", 32'(r.cyc), 32'(e.cyc));
      chk("halt pc", 32'(pc), 32'(e.pc));
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (mem_req || !halted || alu_en || reg_write) cnt++;
      end
      chk("halt hold", 32'(cnt), 32'd0);
      chk("halt state", 32'(state_o), 32'd5);

      // async reset in the middle of a MEM access
      rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (mem_req) break;
      end
      e = ref_step(16'hA040, 1'b0, 8'h00, 0, 0);
      exec(16'hA040, 1'b0, 0, 0, r);
      chk("pre-rst jump pc", 32'(pc), 32'(e.pc));
      mem_rdata = 16'h8512; mem_ready = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (state_o == 3'd3) break;
         @(negedge clk);
      end
      chk("mid-mem req", 32'({mem_req, mem_addr}), 32'({1'b1, 8'h12}));
      #2 rst_n = 1'b0;
      #1;
      chk("async rst req", 32'(mem_req), 32'd0);
      chk("async rst pc", 32'(pc), 32'd0);
      chk("async rst state", 32'(state_o), 32'd0);
      chk("async rst ir", 32'(ir), 32'd0);

      // RAM never answers
      mem_ready = 1'b0; run = 1'b1;
      @(negedge clk); rst_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (fault) break;
         if (mem_req) cnt++;
      end
`ifdef CPU_SEQ_MEM_TIMEOUT_EN
      chk("tmo fault", 32'(fault), 32'd1);
      chk("tmo state", 32'(state_o), 32'd6);
      chk("tmo req off", 32'(mem_req), 32'd0);
      chk("tmo wait cycles", 32'(cnt), 32'd15);
`else
      chk("no-tmo fault", 32'(fault), 32'd0);
      chk("no-tmo state", 32'(state_o), 32'd0);
      chk("no-tmo req held", 32'(mem_req), 32'd1);
      chk("no-tmo wait cycles", 32'(cnt), 32'd60);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Multi-cycle fetch/decode/execute sequencer for the 16-bit CPU.
- Owns the PC and the instruction register (IR), and drives the IR into the control unit.
- Arbitrates the single RAM port between instruction fetch and LOAD/STORE data access.
- Issues one-cycle ALU-enable and register-write strobes, and resolves JUMP/BRANCH using the control unit's branch_check.

Parameters:
- PC_W, 8, PC and RAM address width.
- INSTR_W, 16, instruction and RAM data width.
- RESET_PC, 0, PC value after reset.
- MEM_TIMEOUT, 15, maximum cycles to wait for mem_ready (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  when 0, no new fetch is started.
- mem_rdata  in  INSTR_W  RAM read data, valid when mem_ready=1.
- mem_ready  in  1  RAM completes the current request this cycle.
- branch_check  in  1  branch condition from the control unit.
- mem_req  out  1  RAM request.
- mem_we  out  1  1 = write (STORE), 0 = read.
- mem_addr  out  PC_W  RAM address.
- pc  out  PC_W  program counter.
- ir  out  INSTR_W  instruction register, feeds the control unit.
- alu_en  out  1  one-cycle ALU execute strobe.
- reg_write  out  1  one-cycle register-file write strobe.
- halted  out  1  HALT executed.
- fault  out  1  memory timeout (tied 0 without the optional feature).
- state_o  out  3  current state encoding.

Behaviour:
- Instruction format:
  - [15:12] opcode
  - [11:10] reg1
  - [9:8] reg2
  - [7:0] address/target
- Opcode classes:
  - 0000 NOP
  - 0001–0111 ALU
  - 1000 LOAD
  - 1001 STORE
  - 1010 JUMP
  - 1011 BRANCH
  - 1111 HALT
  - 1100–1110 are treated as NOP.
- States: FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT, FAULT.
- Output timing: all outputs are Moore functions of the state and IR registers only; there is no input-to-output combinational path.
- Reset (asynchronous, any time, including mid-request):
  - state=FETCH, pc=RESET_PC, ir=0.
  - mem_req, mem_we, alu_en, reg_write, halted and fault are all 0.
  - Any in-flight RAM request is abandoned.
- FETCH:
  - If run=0: mem_req=0, stay in FETCH.
  - Otherwise: mem_req=1, mem_we=0, mem_addr=pc. Address and request are held stable until mem_ready=1.
  - On mem_ready: ir<=mem_rdata, go to DECODE.
  - mem_ready with mem_req=0 is ignored.
- DECODE: one cycle, no strobes, go to EXECUTE.
- EXECUTE, by opcode class:
  - ALU: alu_en=1, go to WRITEBACK.
  - LOAD/STORE: go to MEM.
  - JUMP: pc<=ir[7:0], go to FETCH.
  - BRANCH: sample branch_check this cycle; pc<=ir[7:0] if 1, else pc+1; go to FETCH.
  - NOP: pc<=pc+1, go to FETCH.
  - HALT: go to HALT; pc is not incremented.
- MEM:
  - mem_req=1, mem_addr=ir[7:0], mem_we=1 for STORE, 0 for LOAD. Held stable until mem_ready.
  - On ready, LOAD goes to WRITEBACK.
  - On ready, STORE does pc<=pc+1 and goes to FETCH.
- WRITEBACK: reg_write=1 for exactly one cycle, pc<=pc+1, go to FETCH.
- HALT: halted=1, sticky until reset; all request/strobe outputs are 0.
- PC arithmetic is modulo 2^PC_W: 8'hFF+1 = 8'h00.
- Cycle counts with zero-wait RAM (mem_ready high in the first cycle of mem_req):
  - NOP/JUMP/BRANCH: 3
  - ALU: 4
  - STORE: 4
  - LOAD: 5
- Each RAM wait cycle adds 1.
- run=0 is sampled only in FETCH before a request starts. A fetch already in progress (mem_req already high) completes regardless of run.
- state_o encoding: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, HALT=5, FAULT=6.

Optional Feature:
- Macro: CPU_SEQ_MEM_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to FETCH/MEM and counts each cycle in which mem_req=1 and mem_ready=0.
  - When the count reaches MEM_TIMEOUT, go to FAULT: fault=1, mem_req=0, sticky until reset.
  - The counter is cleared on mem_ready and on reset.
- Undefined:
  - No counter is present; fault is tied to 0; the FAULT state is unreachable.

Decomposition:
- Package cpu_seq_pkg holds:
  - the state enum with the encodings above;
  - opcode constants;
  - the opcode class enum (NOP, ALU, LOAD, STORE, JUMP, BRANCH, HALT);
  - field-position constants.
- Sub-module cpu_seq_opdecode: purely combinational, maps ir[15:12] to the opcode class. It is shared with the control unit bench.

Test Plan:
- ALU op 16'h4D00, mem_ready always 1 -> alu_en high in cycle 3, reg_write high in cycle 4, pc 0->1, back in FETCH at cycle 5.
- LOAD 16'h8512 with a 2-cycle ready delay in MEM -> mem_addr=8'h12, mem_we=0 held 3 cycles; reg_write 1 cycle after ready; pc+1.
- BRANCH 16'hB0A0 at pc=5: branch_check=1 -> pc=8'hA0; branch_check=0 -> pc=6. JUMP 16'hA0FF -> pc=8'hFF, then a NOP wraps pc to 8'h00.
- STORE 16'h9033 -> mem_we=1, mem_addr=8'h33 until ready, no reg_write; HALT 16'hF000 -> halted=1 and mem_req stays 0 for 20 cycles.
- Assert rst_n=0 mid-MEM with mem_req high -> same-cycle async clear: mem_req=0, pc=RESET_PC, state_o=0. run=0 in FETCH -> no mem_req.
- With CPU_SEQ_MEM_TIMEOUT_EN and mem_ready held 0 -> fault=1 after 15 wait cycles, state_o=6. Without the macro -> waits indefinitely, fault=0.
